// File: rtl/motor_pkg.sv
// Shared definitions for the motor command bank.
//   ch_state_t : per-channel FSM state (IDLE, DEAD)
//   DATA_LSB   : lowest bit of the speed/data field in a command word
//   dir_bit()  : bit index of the direction flag for a given data width
//   chg_bit()  : bit index of the change flag for a given data width
// Command word layout: {ignored.., change, dir, data[DATA_W-1:0]}.
package motor_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    DEAD = 1'b1
  } ch_state_t;

  localparam int DATA_LSB = 0;

  function automatic int dir_bit(input int data_w);
    return DATA_LSB + data_w;
  endfunction

  function automatic int chg_bit(input int data_w);
    return DATA_LSB + data_w + 1;
  endfunction

endpackage

// File: rtl/motor_cmd_bank_if.sv
// Host-side command bus of the motor command bank.
//   wr_valid / wr_ready : write handshake
//   wr_ch               : target channel index
//   wr_data             : command word
//   wr_err              : one-cycle pulse after a write to a non-existent channel
//   commit              : apply all pending shadows
// Handshake: a write transfers on every rising clock edge where wr_valid and
// wr_ready are both 1; wr_ch/wr_data must be stable while wr_valid is 1.
// wr_ready never depends on wr_valid. commit is a plain strobe sampled every
// edge and needs no handshake.
interface motor_cmd_bank_if #(
  parameter int NUM_CH = 4,
  parameter int WORD_W = 16
);
  localparam int CH_W = $clog2(NUM_CH) + 1;

  logic              wr_valid;
  logic              wr_ready;
  logic [CH_W-1:0]   wr_ch;
  logic [WORD_W-1:0] wr_data;
  logic              wr_err;
  logic              commit;

  modport master (
    output wr_valid, wr_ch, wr_data, commit,
    input  wr_ready, wr_err
  );

  modport slave (
    input  wr_valid, wr_ch, wr_data, commit,
    output wr_ready, wr_err
  );

endinterface

// File: rtl/motor_cmd_channel.sv
// One motor channel: shadow register, active register, IDLE/DEAD FSM and
// dead-time counter.
//   clk, reset     : clock, asynchronous active-low reset
//   i_wr           : write the shadow this cycle
//   i_wr_word      : {change, dir, data} to write
//   i_commit       : global commit strobe
//   o_data/o_dir   : active data and direction
//   o_change_pulse : one-cycle pulse when an applied change bit differs
//   o_pending      : shadow written since last apply
//   o_busy         : channel is in dead time
//   o_state        : FSM state for observation
module motor_cmd_channel
  import motor_pkg::*;
#(
  parameter int DATA_W       = 11,
  parameter int DEADTIME_CYC = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr,
  input  logic [DATA_W+1:0] i_wr_word,
  input  logic              i_commit,
  output logic [DATA_W-1:0] o_data,
  output logic              o_dir,
  output logic              o_change_pulse,
  output logic              o_pending,
  output logic              o_busy,
  output ch_state_t         o_state
);

  localparam int DIR_BIT = dir_bit(DATA_W);
  localparam int CHG_BIT = chg_bit(DATA_W);
  // Keep at least one counter bit so a disabled dead time still elaborates.
  localparam int CNT_W = (DEADTIME_CYC > 0) ? $clog2(DEADTIME_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (DEADTIME_CYC > 0) ? CNT_W'(DEADTIME_CYC - 1) : '0;

  logic [DATA_W+1:0] r_shadow;
  logic [DATA_W+1:0] r_held;
  logic              r_pending;
  logic [DATA_W-1:0] r_data;
  logic              r_dir;
  logic              r_chg;
  logic              r_pulse;
  logic [CNT_W-1:0]  r_cnt;
  ch_state_t         r_state;

  logic w_apply;
  logic w_reversal;
  logic w_shadow_toggles;
  logic w_held_toggles;

  assign w_apply = i_commit && r_pending;

  // A reversal only needs dead time if the motor is actually moving.
  assign w_reversal = (r_shadow[DIR_BIT] != r_dir) && (r_data != '0) &&
                      (DEADTIME_CYC != 0);

  // Suppress a pulse right after another so the pulse never stretches.
  assign w_shadow_toggles = (r_shadow[CHG_BIT] != r_chg) && !r_pulse;
  assign w_held_toggles   = (r_held[CHG_BIT] != r_chg) && !r_pulse;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow  <= '0;
      r_held    <= '0;
      r_pending <= 1'b0;
      r_data    <= '0;
      r_dir     <= 1'b0;
      r_chg     <= 1'b0;
      r_pulse   <= 1'b0;
      r_cnt     <= '0;
      r_state   <= IDLE;
    end else begin
      r_pulse <= 1'b0;

      // A write in the commit cycle wins over the clear: the commit took the
      // pre-write shadow, and the new word waits for the next commit.
      if (i_wr) begin
        r_shadow  <= i_wr_word;
        r_pending <= 1'b1;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_apply) begin
            if (w_reversal) begin
              r_state <= DEAD;
              r_data  <= '0;
              r_held  <= r_shadow;
              r_cnt   <= CNT_LOAD;
            end else begin
              r_data  <= r_shadow[DATA_LSB +: DATA_W];
              r_dir   <= r_shadow[DIR_BIT];
              r_chg   <= r_shadow[CHG_BIT];
              r_pulse <= w_shadow_toggles;
            end
          end
        end

        DEAD: begin
          if (w_apply) begin
            r_held <= r_shadow;
            if (r_shadow[DIR_BIT] == r_dir) begin
              // Host returned to the original direction: no dead time needed.
              r_state <= IDLE;
              r_cnt   <= '0;
              r_data  <= r_shadow[DATA_LSB +: DATA_W];
              r_dir   <= r_shadow[DIR_BIT];
              r_chg   <= r_shadow[CHG_BIT];
              r_pulse <= w_shadow_toggles;
            end else begin
              r_cnt <= CNT_LOAD;
            end
          end else if (r_cnt == '0) begin
            r_state <= IDLE;
            r_data  <= r_held[DATA_LSB +: DATA_W];
            r_dir   <= r_held[DIR_BIT];
            r_chg   <= r_held[CHG_BIT];
            r_pulse <= w_held_toggles;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_data         = r_data;
  assign o_dir          = r_dir;
  assign o_change_pulse = r_pulse;
  assign o_pending      = r_pending;
  assign o_busy         = (r_state == DEAD);
  assign o_state        = r_state;

endmodule

// File: rtl/motor_cmd_bank.sv
// Multi-channel double-buffered motor command register bank. Host writes go
// to per-channel shadows; commit moves every pending shadow to the active
// outputs at once, with a zero-speed dead time on direction reversals.
//   clk, reset   : clock, asynchronous active-low reset
//   bus          : host command bus (slave side)
//   data_out     : active data, channel c at [c*DATA_W +: DATA_W]
//   direction    : active direction per channel
//   change_pulse : per-channel change pulse
//   pending      : per-channel shadow-written flag
//   busy         : per-channel dead-time flag
//   o_dbg_state  : per-channel FSM state (1 = DEAD)
// WORD_W must be at least DATA_W+2.
module motor_cmd_bank
  import motor_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DATA_W       = 11,
  parameter int WORD_W       = 16,
  parameter int DEADTIME_CYC = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  motor_cmd_bank_if.slave          bus,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_CH-1:0]        direction,
  output logic [NUM_CH-1:0]        change_pulse,
  output logic [NUM_CH-1:0]        pending,
  output logic [NUM_CH-1:0]        busy,
  output logic [NUM_CH-1:0]        o_dbg_state
);

  localparam int CH_W = $clog2(NUM_CH) + 1;

  logic      r_wr_ready;
  logic      r_wr_err;
  logic      w_wr_fire;
  logic      w_ch_ok;
  ch_state_t w_state [NUM_CH];

  assign w_wr_fire = bus.wr_valid && r_wr_ready;
  assign w_ch_ok   = (bus.wr_ch < CH_W'(NUM_CH));

  // Ready comes up one cycle after reset release and then stays up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ready <= 1'b0;
      r_wr_err   <= 1'b0;
    end else begin
      r_wr_ready <= 1'b1;
      r_wr_err   <= w_wr_fire && !w_ch_ok;
    end
  end

  assign bus.wr_ready = r_wr_ready;
  assign bus.wr_err   = r_wr_err;

  // Command bits above the change flag carry nothing.
  if (WORD_W > DATA_W + 2) begin : g_hi_bits
    logic w_unused_hi;
    assign w_unused_hi = ^bus.wr_data[WORD_W-1:DATA_W+2];
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic w_wr_en;
    assign w_wr_en = w_wr_fire && (bus.wr_ch == CH_W'(c));

    motor_cmd_channel #(
      .DATA_W       (DATA_W),
      .DEADTIME_CYC (DEADTIME_CYC)
    ) u_ch (
      .clk            (clk),
      .reset          (reset),
      .i_wr           (w_wr_en),
      .i_wr_word      (bus.wr_data[DATA_W+1:0]),
      .i_commit       (bus.commit),
      .o_data         (data_out[c*DATA_W +: DATA_W]),
      .o_dir          (direction[c]),
      .o_change_pulse (change_pulse[c]),
      .o_pending      (pending[c]),
      .o_busy         (busy[c]),
      .o_state        (w_state[c])
    );

    assign o_dbg_state[c] = (w_state[c] == DEAD);
  end

endmodule

// File: tb/tb_motor_cmd_bank.sv
module tb_motor_cmd_bank;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 11;
  localparam int WORD_W = 16;
  localparam int DEAD   = 8;
  localparam int W      = 62;
  // Expected-vector layout: data[43:0], dir[47:44], pulse[51:48],
  // pending[55:52], busy[59:56], wr_err[60], wr_ready[61].

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  motor_cmd_bank_if #(.NUM_CH(NUM_CH), .WORD_W(WORD_W)) bus ();

  logic [NUM_CH*DATA_W-1:0] data_out;
  logic [NUM_CH-1:0]        direction;
  logic [NUM_CH-1:0]        change_pulse;
  logic [NUM_CH-1:0]        pending;
  logic [NUM_CH-1:0]        busy;
  logic [NUM_CH-1:0]        dbg_state;

  motor_cmd_bank #(
    .NUM_CH       (NUM_CH),
    .DATA_W       (DATA_W),
    .WORD_W       (WORD_W),
    .DEADTIME_CYC (DEAD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .data_out     (data_out),
    .direction    (direction),
    .change_pulse (change_pulse),
    .pending      (pending),
    .busy         (busy),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- reference model ----------------
  // Dead time is tracked as the absolute edge number on which the held word
  // lands, rather than as a countdown.
  int          cyc;
  logic [12:0] m_shadow  [NUM_CH];
  logic [12:0] m_held    [NUM_CH];
  bit          m_pend    [NUM_CH];
  logic [10:0] m_data    [NUM_CH];
  bit          m_dir     [NUM_CH];
  bit          m_chg     [NUM_CH];
  bit          m_dead    [NUM_CH];
  int          m_release [NUM_CH];
  bit          m_pulse   [NUM_CH];
  bit          m_err;
  bit          m_rdy;

  logic [W-1:0] exp_q [$];
  int n_total = 0;
  int n_bad   = 0;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_shadow[c] = '0; m_held[c] = '0; m_pend[c] = 0; m_data[c] = '0;
      m_dir[c] = 0; m_chg[c] = 0; m_dead[c] = 0; m_release[c] = 0; m_pulse[c] = 0;
    end
    m_err = 0;
    m_rdy = 0;
  endtask

  task automatic model_apply(input int c, input logic [12:0] w, input bit prev);
    m_pulse[c] = (w[12] != m_chg[c]) && !prev;
    m_data[c]  = w[10:0];
    m_dir[c]   = w[11];
    m_chg[c]   = w[12];
    m_dead[c]  = 0;
  endtask

  task automatic model_edge(input bit v, input logic [2:0] ch,
                            input logic [15:0] d, input bit cm);
    bit prev [NUM_CH];
    bit ap;
    for (int c = 0; c < NUM_CH; c++) begin
      prev[c]    = m_pulse[c];
      m_pulse[c] = 0;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      ap = cm && m_pend[c];
      if (m_dead[c]) begin
        if (ap) begin
          m_held[c] = m_shadow[c];
          if (m_shadow[c][11] == m_dir[c]) model_apply(c, m_shadow[c], prev[c]);
          else m_release[c] = cyc + DEAD;
        end else if (cyc == m_release[c]) begin
          model_apply(c, m_held[c], prev[c]);
        end
      end else if (ap) begin
        if (m_shadow[c][11] == m_dir[c] || m_data[c] == 0) begin
          model_apply(c, m_shadow[c], prev[c]);
        end else begin
          m_dead[c]    = 1;
          m_data[c]    = '0;
          m_held[c]    = m_shadow[c];
          m_release[c] = cyc + DEAD;
        end
      end
      if (ap) m_pend[c] = 0;
    end
    m_err = 0;
    if (v && m_rdy) begin
      if (int'(ch) < NUM_CH) begin
        m_shadow[ch] = d[12:0];
        m_pend[ch]   = 1;
      end else begin
        m_err = 1;
      end
    end
    m_rdy = 1;
    cyc++;
  endtask

  function automatic logic [W-1:0] model_pack();
    logic [W-1:0] p;
    p = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      p[c*DATA_W +: DATA_W] = m_data[c];
      p[44 + c] = m_dir[c];
      p[48 + c] = m_pulse[c];
      p[52 + c] = m_pend[c];
      p[56 + c] = m_dead[c];
    end
    p[60] = m_err;
    p[61] = m_rdy;
    return p;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got=0x%0h expected=0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic compare_outputs();
    logic [W-1:0] e;
    e = exp_q.pop_front();
    check_eq("data_out",     64'(data_out),     64'(e[43:0]));
    check_eq("direction",    64'(direction),    64'(e[47:44]));
    check_eq("change_pulse", 64'(change_pulse), 64'(e[51:48]));
    check_eq("pending",      64'(pending),      64'(e[55:52]));
    check_eq("busy",         64'(busy),         64'(e[59:56]));
    check_eq("dbg_state",    64'(dbg_state),    64'(e[59:56]));
    check_eq("wr_err",       64'(bus.wr_err),   64'(e[60]));
    check_eq("wr_ready",     64'(bus.wr_ready), 64'(e[61]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit v, input logic [2:0] ch, input logic [15:0] d, input bit cm);
    bus.wr_valid = v;
    bus.wr_ch    = ch;
    bus.wr_data  = d;
    bus.commit   = cm;
    @(posedge clk);
    if (reset) model_edge(v, ch, d, cm);
    exp_q.push_back(model_pack());
    #1;
    compare_outputs();
  endtask

  task automatic wr(input logic [2:0] ch, input logic [15:0] d);
    step(1'b1, ch, d, 1'b0);
  endtask

  task automatic cmt();
    step(1'b0, 3'd0, 16'h0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 16'h0, 1'b0);
  endtask

  task automatic release_reset();
    reset = 1'b1;
    #1;
    check_eq("ready_after_release", 64'(bus.wr_ready), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_ch    = '0;
    bus.wr_data  = '0;
    bus.commit   = 1'b0;
    cyc = 0;
    model_reset();
    idle(3);
    release_reset();
    idle(2);

    // two channels written then committed together
    wr(3'd0, 16'h0155);
    wr(3'd2, 16'h0200);
    cmt();
    idle(2);

    // reversal on a moving channel: dead time then new direction
    wr(3'd0, 16'h0955);
    cmt();
    idle(DEAD + 2);

    // back to dir0, then reverse again and abort by returning to dir0
    wr(3'd0, 16'h0155);
    cmt();
    idle(DEAD + 2);
    wr(3'd0, 16'h0955);
    cmt();
    idle(2);
    wr(3'd0, 16'h0100);
    cmt();
    idle(DEAD + 2);

    // change bit toggle pulses once; recommitting the same word does not
    wr(3'd3, 16'h1000);
    cmt();
    idle(2);
    wr(3'd3, 16'h1000);
    cmt();
    idle(2);

    // out-of-range channel, then write and commit in one cycle
    step(1'b1, 3'd5, 16'h07FF, 1'b0);
    idle(2);
    wr(3'd1, 16'h0033);
    step(1'b1, 3'd1, 16'h0044, 1'b1);
    idle(1);
    cmt();
    idle(2);

    // upper bits ignored
    wr(3'd2, 16'hE2AA);
    cmt();
    idle(2);

    // asynchronous reset in the middle of a dead time on ch1
    wr(3'd1, 16'h0010);
    cmt();
    wr(3'd1, 16'h0810);
    cmt();
    idle(3);
    check_eq("busy1_before_reset", 64'(busy[1]), 64'd1);
    #3;
    reset = 1'b0;
    #1;
    check_eq("rst_data",    64'(data_out),     64'd0);
    check_eq("rst_dir",     64'(direction),    64'd0);
    check_eq("rst_busy",    64'(busy),         64'd0);
    check_eq("rst_pending", 64'(pending),      64'd0);
    check_eq("rst_pulse",   64'(change_pulse), 64'd0);
    check_eq("rst_ready",   64'(bus.wr_ready), 64'd0);
    check_eq("rst_err",     64'(bus.wr_err),   64'd0);
    model_reset();
    idle(2);
    release_reset();
    idle(2);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 5)), d,
           ($urandom_range(0, 3) == 0));
      if (i % 150 == 149) idle(DEAD + 3);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
